nram_readout: RTL and testbench
===============================

Name: nram_readout

Overview:
- Downstream consumer of the NRAM register bank.
- On a start request, captures all NREG register words (Qbus) in one cycle, then streams them out one word per handshake on a valid/ready interface, lowest index first.
- Gives an atomic, backpressure-tolerant readout of the bank to a host or serial link stage.

Parameters:
- W, 8, word width; matches NRAM data width.
- NREG, 2, number of NRAM words scanned.
- IDX_W, 2, width of the word index output; must satisfy 2^IDX_W > NREG.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- io_Qbus  in  NREG*W  concatenated NRAM outputs; word k is at bits [k*W+W-1 : k*W] (io_Qbus_0 is the LSBs).
- io_start  in  1  request a snapshot and readout; sampled only in IDLE.
- io_out_ready  in  1  sink can accept the current word.
- io_out_valid  out  1  io_out_bits and io_out_idx hold a valid word.
- io_out_bits  out  W  streamed word.
- io_out_idx  out  IDX_W  index of the streamed word.
- io_busy  out  1  high in SEND and DONE.
- io_done  out  1  one-cycle pulse after the final word handshake.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; snapshot regs=0; index counter=0.
  - io_out_valid=0, io_out_bits=0, io_out_idx=0, io_busy=0, io_done=0.
  - Takes effect mid-stream with no partial completion; io_done is not pulsed.
- States: IDLE, SEND, DONE.
- IDLE:
  - Outputs are idle.
  - io_start=1 at a rising edge: all NREG words of io_Qbus are captured into snapshot regs, counter is set to 0, and state moves to SEND.
  - io_out_valid rises in the cycle after io_start is sampled (latency 1).
- SEND:
  - io_out_valid=1; io_out_bits=snapshot[counter]; io_out_idx=counter.
  - Handshake = io_out_valid & io_out_ready at a rising edge.
  - On handshake with counter<NREG-1: counter increments and the next word is presented in the following cycle. Back-to-back handshakes give one word per cycle.
  - On handshake with counter=NREG-1: state moves to DONE and io_out_valid drops.
  - While io_out_valid=1 and io_out_ready=0: io_out_bits and io_out_idx hold stable, valid is never withdrawn.
- DONE:
  - io_done=1 for exactly one cycle, then state moves to IDLE.
  - A new io_start is therefore accepted no earlier than 2 cycles after the last handshake.
- io_start in SEND or DONE is ignored, not queued.
- Changes on io_Qbus after capture do not affect the streamed data; NRAM writes during readout are invisible until the next start.
- io_busy=1 exactly in SEND and DONE.
- Counter never exceeds NREG-1 in SEND; no wrap occurs.
- NREG=1 is legal: one word is sent, then DONE.

Optional Feature:
- Macro NRAM_READOUT_CHECKSUM_EN.
- Defined:
  - After word NREG-1 is handshaken, the FSM enters CSUM instead of DONE.
  - CSUM presents io_out_bits = XOR of all snapshot words and io_out_idx = NREG, with the same valid/ready and hold rules as SEND.
  - The CSUM handshake moves to DONE; io_done pulses after the checksum word.
- Undefined: no CSUM state; behaviour as above.

Test Plan:
- Basic: Qbus_0=0xA5, Qbus_1=0x3C, ready=1, pulse start -> valid at cycle+1 with (idx0, 0xA5), then (idx1, 0x3C) next cycle, valid low, io_done pulse one cycle later, busy high throughout.
- Backpressure: same data, ready=0 for 3 cycles after valid rises -> bits hold 0xA5 / idx0 for 3 cycles; after ready=1, 0x3C follows; no word is dropped or duplicated.
- Snapshot isolation: start with Qbus_1=0x3C, change Qbus_1 to 0xFF one cycle later -> stream still carries 0x3C.
- Start while busy: assert start during SEND -> ignored; exactly 2 words and 1 done pulse; a start sampled in IDLE afterwards produces a fresh readout.
- Async reset mid-stream: drop reset low while bits=0xA5 and ready=0 -> valid, busy, done all 0 immediately without a clock edge; after release the FSM is in IDLE.
- Checksum (macro defined): 0xA5, 0x3C -> third word idx2 = 0x99, then done pulse.

Source files
------------

// File: rtl/nram_readout.sv
// nram_readout: snapshots the NRAM register bank on a start request and
// streams the captured words out over a valid/ready interface, lowest index
// first, with a one-cycle io_done pulse after the final word.
// Optional build macro: NRAM_READOUT_CHECKSUM_EN appends an XOR checksum word
// (index NREG) after the data words.
module nram_readout #(
  parameter int W     = 8,
  parameter int NREG  = 2,
  parameter int IDX_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREG*W-1:0]   io_Qbus,
  input  logic                io_start,
  input  logic                io_out_ready,
  output logic                io_out_valid,
  output logic [W-1:0]        io_out_bits,
  output logic [IDX_W-1:0]    io_out_idx,
  output logic                io_busy,
  output logic                io_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
`ifdef NRAM_READOUT_CHECKSUM_EN
    S_CSUM = 2'd3,
`endif
    S_DONE = 2'd2
  } state_t;

  // Select word k of a packed bank image.
  function automatic logic [W-1:0] word_at(input logic [NREG*W-1:0] v,
                                           input logic [IDX_W-1:0]  k);
    logic [W-1:0] r;
    r = {W{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      r = (k == IDX_W'(i)) ? v[i*W +: W] : r;
    end
    return r;
  endfunction

`ifdef NRAM_READOUT_CHECKSUM_EN
  // XOR of every word in a packed bank image.
  function automatic logic [W-1:0] xor_words(input logic [NREG*W-1:0] v);
    logic [W-1:0] r;
    r = {W{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      r = r ^ v[i*W +: W];
    end
    return r;
  endfunction
`endif

  state_t              state_q, state_d;
  logic [NREG*W-1:0]   snap_q, snap_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic [W-1:0]        bits_q, bits_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                hs_s;
  logic                last_s;
  logic [IDX_W-1:0]    cnt_inc_s;

  assign hs_s      = valid_q & io_out_ready;
  assign last_s    = (cnt_q == IDX_W'(NREG - 1));
  assign cnt_inc_s = cnt_q + IDX_W'(1);

  // Next-state and next-output computation; outputs are registered so each
  // branch sets the values to be presented in the following cycle.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    bits_d  = bits_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (io_start) begin
          snap_d  = io_Qbus;
          cnt_d   = {IDX_W{1'b0}};
          state_d = S_SEND;
          valid_d = 1'b1;
          bits_d  = io_Qbus[W-1:0];
          idx_d   = {IDX_W{1'b0}};
          busy_d  = 1'b1;
        end else begin
          valid_d = 1'b0;
          bits_d  = {W{1'b0}};
          idx_d   = {IDX_W{1'b0}};
          busy_d  = 1'b0;
        end
      end
      S_SEND: begin
        if (hs_s && last_s) begin
`ifdef NRAM_READOUT_CHECKSUM_EN
          state_d = S_CSUM;
          bits_d  = xor_words(snap_q);
          idx_d   = IDX_W'(NREG);
`else
          state_d = S_DONE;
          valid_d = 1'b0;
          bits_d  = {W{1'b0}};
          idx_d   = {IDX_W{1'b0}};
          done_d  = 1'b1;
`endif
        end else if (hs_s) begin
          cnt_d  = cnt_inc_s;
          bits_d = word_at(snap_q, cnt_inc_s);
          idx_d  = cnt_inc_s;
        end else begin
          // Backpressure: hold the presented word.
          state_d = S_SEND;
        end
      end
`ifdef NRAM_READOUT_CHECKSUM_EN
      S_CSUM: begin
        if (hs_s) begin
          state_d = S_DONE;
          valid_d = 1'b0;
          bits_d  = {W{1'b0}};
          idx_d   = {IDX_W{1'b0}};
          done_d  = 1'b1;
        end else begin
          state_d = S_CSUM;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        bits_d  = {W{1'b0}};
        idx_d   = {IDX_W{1'b0}};
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, snapshot and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      snap_q  <= {(NREG*W){1'b0}};
      cnt_q   <= {IDX_W{1'b0}};
      valid_q <= 1'b0;
      bits_q  <= {W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      bits_q  <= bits_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign io_out_valid = valid_q;
  assign io_out_bits  = bits_q;
  assign io_out_idx   = idx_q;
  assign io_busy      = busy_q;
  assign io_done      = done_q;

endmodule

// File: tb/tb_nram_readout.sv
// Table-driven bench for nram_readout (NREG=2) plus hand sequences for
// asynchronous reset mid-stream and an NREG=1 instance.
module tb_nram_readout;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] qbus;
  logic        start;
  logic        ready;
  logic        valid;
  logic [7:0]  bits;
  logic [1:0]  idx;
  logic        busy;
  logic        done;

  logic [7:0]  q1;
  logic        start1;
  logic        valid1;
  logic [7:0]  bits1;
  logic [0:0]  idx1;
  logic        busy1;
  logic        done1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  nram_readout #(.W(8), .NREG(2), .IDX_W(2)) dut (
    .clk(clk), .reset(reset), .io_Qbus(qbus), .io_start(start),
    .io_out_ready(ready), .io_out_valid(valid), .io_out_bits(bits),
    .io_out_idx(idx), .io_busy(busy), .io_done(done)
  );

  nram_readout #(.W(8), .NREG(1), .IDX_W(1)) dut1 (
    .clk(clk), .reset(reset), .io_Qbus(q1), .io_start(start1),
    .io_out_ready(ready), .io_out_valid(valid1), .io_out_bits(bits1),
    .io_out_idx(idx1), .io_busy(busy1), .io_done(done1)
  );

  typedef struct {
    logic        s;
    logic        r;
    logic [15:0] q;
    logic        ev;
    logic [7:0]  eb;
    logic [1:0]  ei;
    logic        ebusy;
    logic        edone;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic add(input logic s, input logic r, input logic [15:0] q,
                     input logic ev, input logic [7:0] eb, input logic [1:0] ei,
                     input logic ebusy, input logic edone);
    vec_t v;
    v.s = s; v.r = r; v.q = q; v.ev = ev; v.eb = eb; v.ei = ei;
    v.ebusy = ebusy; v.edone = edone;
    vecs.push_back(v);
  endtask

  // Rows after the last data handshake: optional checksum word, done pulse, idle.
  task automatic end_rows(input logic s, input logic [15:0] q, input logic [7:0] cs);
`ifdef NRAM_READOUT_CHECKSUM_EN
    add(s, 1'b1, q, 1'b1, cs, 2'd2, 1'b1, 1'b0);
`endif
    add(s, 1'b1, q, 1'b0, 8'h00, 2'd0, 1'b1, 1'b1);
    add(s, 1'b1, q, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    // Basic readout
    add(1'b0, 1'b1, 16'h3CA5, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 16'h3CA5, 1'b1, 8'hA5, 2'd0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 16'h3CA5, 1'b1, 8'h3C, 2'd1, 1'b1, 1'b0);
    end_rows(1'b0, 16'h3CA5, 8'h99);
    // Backpressure: three held cycles on word 0, one on word 1
    add(1'b1, 1'b0, 16'h3CA5, 1'b1, 8'hA5, 2'd0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 16'h3CA5, 1'b1, 8'hA5, 2'd0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 16'h3CA5, 1'b1, 8'hA5, 2'd0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 16'h3CA5, 1'b1, 8'hA5, 2'd0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 16'h3CA5, 1'b1, 8'h3C, 2'd1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 16'h3CA5, 1'b1, 8'h3C, 2'd1, 1'b1, 1'b0);
    end_rows(1'b0, 16'h3CA5, 8'h99);
    // Snapshot isolation: bank changes after capture
    add(1'b1, 1'b1, 16'h3CA5, 1'b1, 8'hA5, 2'd0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 16'hFFA5, 1'b1, 8'h3C, 2'd1, 1'b1, 1'b0);
    end_rows(1'b0, 16'hFFFF, 8'h99);
    // Start held high while busy is ignored, fresh readout afterwards
    add(1'b1, 1'b0, 16'h3CA5, 1'b1, 8'hA5, 2'd0, 1'b1, 1'b0);
    add(1'b1, 1'b1, 16'h1111, 1'b1, 8'h3C, 2'd1, 1'b1, 1'b0);
    end_rows(1'b1, 16'h1111, 8'h99);
    add(1'b1, 1'b0, 16'h7755, 1'b1, 8'h55, 2'd0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 16'h7755, 1'b1, 8'h77, 2'd1, 1'b1, 1'b0);
    end_rows(1'b0, 16'h7755, 8'h22);

    reset = 1'b0; start = 1'b0; ready = 1'b0; qbus = 16'h0000;
    start1 = 1'b0; q1 = 8'h00;
    #12;
    chk("reset_state", {valid, bits, idx, busy, done}, 32'h0);
    chk("reset_state1", {valid1, bits1, idx1, busy1, done1}, 32'h0);
    @(negedge clk) reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      start = vecs[i].s; ready = vecs[i].r; qbus = vecs[i].q;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_ctl", i), {29'd0, valid, busy, done},
          {29'd0, vecs[i].ev, vecs[i].ebusy, vecs[i].edone});
      if (vecs[i].ev) begin
        chk($sformatf("row%0d_data", i), {22'd0, idx, bits}, {22'd0, vecs[i].ei, vecs[i].eb});
      end
    end

    // Asynchronous reset in the middle of a stalled stream
    @(negedge clk) start = 1'b1; ready = 1'b0; qbus = 16'h3CA5;
    @(posedge clk) #1;
    @(negedge clk) start = 1'b0;
    @(posedge clk) #1;
    chk("pre_reset_word", {23'd0, valid, bits}, {23'd0, 1'b1, 8'hA5});
    #2 reset = 1'b0;
    #1;
    chk("async_reset_ctl", {29'd0, valid, busy, done}, 32'd0);
    chk("async_reset_data", {22'd0, idx, bits}, 32'd0);
    @(negedge clk) reset = 1'b1; ready = 1'b1;
    @(posedge clk) #1;
    chk("post_reset_idle", {29'd0, valid, busy, done}, 32'd0);
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1;
    chk("post_reset_start", {20'd0, valid, busy, done, idx, bits},
        {20'd0, 1'b1, 1'b1, 1'b0, 2'd0, 8'hA5});
    @(negedge clk) start = 1'b0; reset = 1'b0;
    @(negedge clk) reset = 1'b1;

    // NREG=1: single word then done
    @(negedge clk) start1 = 1'b1; q1 = 8'h5A; ready = 1'b0;
    @(posedge clk) #1;
    chk("n1_word", {21'd0, valid1, busy1, done1, idx1, bits1},
        {21'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A});
    @(negedge clk) start1 = 1'b0; q1 = 8'h00; ready = 1'b1;
    @(posedge clk) #1;
`ifdef NRAM_READOUT_CHECKSUM_EN
    chk("n1_csum", {21'd0, valid1, busy1, done1, idx1, bits1},
        {21'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A});
    @(posedge clk) #1;
`endif
    chk("n1_done", {29'd0, valid1, busy1, done1}, {29'd0, 1'b0, 1'b1, 1'b1});
    @(posedge clk) #1;
    chk("n1_idle", {29'd0, valid1, busy1, done1}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
